// File: rtl/ahb_enum_pkg.sv
// Shared AHB-lite encodings and the address-phase payload used by the mailbox arbiter.
package ahb_enum_pkg;

  localparam int unsigned AHB_ADDR_W = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    AHB_RESP_OKAY  = 2'b00,
    AHB_RESP_ERROR = 2'b01
  } hresp_e;

  typedef struct packed {
    logic [AHB_ADDR_W-1:0] haddr;
    logic [3:0]            hprot;
    logic [2:0]            hsize;
    logic                  hwrite;
  } ahb_addr_req_t;

endpackage

// File: rtl/ahb_arb_port.sv
// One master port of the mailbox arbiter: request detect, one-entry address
// buffer, and the hready/hresp/hrdata return path.
module ahb_arb_port
  import ahb_enum_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [3:0]            hprot,
  input  logic [2:0]            hsize,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic                  fwd,
  input  logic                  issue_buf,
  input  logic                  owner,
  input  logic                  s_hready,
  input  logic [1:0]            s_hresp,
  input  logic [DATA_WIDTH-1:0] s_hrdata,
  output logic                  req_c,
  output ahb_addr_req_t         live_req_c,
  output logic                  buf_valid,
  output ahb_addr_req_t         buf_req,
  output logic                  hready_c,
  output logic [1:0]            hresp_c,
  output logic [DATA_WIDTH-1:0] hrdata_c
);

  logic [DATA_WIDTH-1:0] hrdata_q;

  // A full buffer and data-phase ownership never coexist, so the priority order is safe.
  always_comb begin
    hready_c = 1'b1;
    if (buf_valid) begin
      hready_c = 1'b0;
    end else if (owner) begin
      hready_c = s_hready;
    end
    hresp_c           = owner ? s_hresp : AHB_RESP_OKAY;
    hrdata_c          = owner ? s_hrdata : hrdata_q;
    req_c             = hsel && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ)) && hready_c;
    live_req_c.haddr  = AHB_ADDR_W'(haddr);
    live_req_c.hprot  = hprot;
    live_req_c.hsize  = hsize;
    live_req_c.hwrite = hwrite;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      buf_valid <= 1'b0;
      buf_req   <= '0;
      hrdata_q  <= '0;
    end else begin
      if (issue_buf) begin
        buf_valid <= 1'b0;
      end else if (req_c && !fwd) begin
        buf_valid <= 1'b1;
        buf_req   <= live_req_c;
      end
      if (owner && s_hready) begin
        hrdata_q <= s_hrdata;
      end
    end
  end

endmodule

// File: rtl/ahb_mailbox_arb.sv
// Two-master AHB-lite arbiter in front of the mailbox slave: per-transfer
// round-robin, live pass-through when the slot is free, data phase routed to its owner.
module ahb_mailbox_arb
  import ahb_enum_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  m0_hsel,
  input  logic [ADDR_WIDTH-1:0] m0_haddr,
  input  logic [3:0]            m0_hprot,
  input  logic [2:0]            m0_hsize,
  input  logic [1:0]            m0_htrans,
  input  logic                  m0_hwrite,
  input  logic [DATA_WIDTH-1:0] m0_hwdata,
  output logic                  m0_hready,
  output logic [1:0]            m0_hresp,
  output logic [DATA_WIDTH-1:0] m0_hrdata,
  input  logic                  m1_hsel,
  input  logic [ADDR_WIDTH-1:0] m1_haddr,
  input  logic [3:0]            m1_hprot,
  input  logic [2:0]            m1_hsize,
  input  logic [1:0]            m1_htrans,
  input  logic                  m1_hwrite,
  input  logic [DATA_WIDTH-1:0] m1_hwdata,
  output logic                  m1_hready,
  output logic [1:0]            m1_hresp,
  output logic [DATA_WIDTH-1:0] m1_hrdata,
  output logic                  s_hsel,
  output logic [ADDR_WIDTH-1:0] s_haddr,
  output logic [3:0]            s_hprot,
  output logic [2:0]            s_hsize,
  output logic [1:0]            s_htrans,
  output logic                  s_hwrite,
  output logic [DATA_WIDTH-1:0] s_hwdata,
  input  logic                  s_hready,
  input  logic [1:0]            s_hresp,
  input  logic [DATA_WIDTH-1:0] s_hrdata
);

  logic          req0, req1, bv0, bv1;
  logic          fwd0, fwd1, ibuf0, ibuf1, own0, own1;
  ahb_addr_req_t live0, live1, bq0, bq1, issue_req;
  logic          owner_vld, owner_id, last_id;
  logic          slot_free, grant_vld, grant_id;
  logic          cand0, cand1;

  ahb_arb_port #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_port0 (
    .hclk(hclk), .hresetn(hresetn),
    .hsel(m0_hsel), .haddr(m0_haddr), .hprot(m0_hprot), .hsize(m0_hsize),
    .htrans(m0_htrans), .hwrite(m0_hwrite),
    .fwd(fwd0), .issue_buf(ibuf0), .owner(own0),
    .s_hready(s_hready), .s_hresp(s_hresp), .s_hrdata(s_hrdata),
    .req_c(req0), .live_req_c(live0), .buf_valid(bv0), .buf_req(bq0),
    .hready_c(m0_hready), .hresp_c(m0_hresp), .hrdata_c(m0_hrdata)
  );

  ahb_arb_port #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_port1 (
    .hclk(hclk), .hresetn(hresetn),
    .hsel(m1_hsel), .haddr(m1_haddr), .hprot(m1_hprot), .hsize(m1_hsize),
    .htrans(m1_htrans), .hwrite(m1_hwrite),
    .fwd(fwd1), .issue_buf(ibuf1), .owner(own1),
    .s_hready(s_hready), .s_hresp(s_hresp), .s_hrdata(s_hrdata),
    .req_c(req1), .live_req_c(live1), .buf_valid(bv1), .buf_req(bq1),
    .hready_c(m1_hready), .hresp_c(m1_hresp), .hrdata_c(m1_hrdata)
  );

  // Round-robin grant; a buffered entry always takes precedence over its master's live bus.
  always_comb begin
    slot_free = !owner_vld || s_hready;
    cand0     = req0 || bv0;
    cand1     = req1 || bv1;
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (slot_free) begin
      if (cand0 && cand1) begin
        grant_vld = 1'b1;
        grant_id  = !last_id;
      end else if (cand0) begin
        grant_vld = 1'b1;
      end else if (cand1) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
    if (grant_id) begin
      issue_req = bv1 ? bq1 : live1;
    end else begin
      issue_req = bv0 ? bq0 : live0;
    end
    fwd0  = grant_vld && !grant_id && !bv0;
    ibuf0 = grant_vld && !grant_id && bv0;
    fwd1  = grant_vld && grant_id && !bv1;
    ibuf1 = grant_vld && grant_id && bv1;
    own0  = owner_vld && !owner_id;
    own1  = owner_vld && owner_id;
  end

  always_comb begin
    s_hsel   = grant_vld;
    s_htrans = grant_vld ? HTRANS_NONSEQ : HTRANS_IDLE;
    s_haddr  = grant_vld ? ADDR_WIDTH'(issue_req.haddr) : '0;
    s_hprot  = grant_vld ? issue_req.hprot : 4'h0;
    s_hsize  = grant_vld ? issue_req.hsize : 3'h0;
    s_hwrite = grant_vld && issue_req.hwrite;
    s_hwdata = owner_id ? m1_hwdata : m0_hwdata;
  end

  // Last-granted starts at m1 so m0 wins the first contested slot.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      owner_vld <= 1'b0;
      owner_id  <= 1'b0;
      last_id   <= 1'b1;
    end else if (grant_vld) begin
      owner_vld <= 1'b1;
      owner_id  <= grant_id;
      last_id   <= grant_id;
    end else if (s_hready) begin
      owner_vld <= 1'b0;
    end
  end

endmodule
